// File: rtl/value_to_digits.sv
// Signed 16-bit value to sign + five-digit display code converter.
// A numeric request walks IDLE -> LOAD -> SHIFT (16 double-dabble
// iterations) -> BLANK -> DONE. This gives a fixed latency from the
// accepting edge to the done pulse for every operand.
// An error request bypasses the datapath and shows dashes immediately.
//
// state | meaning
// IDLE  | waiting for start; error requests are served from here
// LOAD  | magnitude and sign taken from the latched operand, BCD cleared
// SHIFT | one double-dabble iteration per cycle, 16 in total
// BLANK | leading-zero blanking applied, display registers updated
// DONE  | done pulse cycle; start is ignored here

module value_to_digits (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        error,
  output logic        busy,
  output logic        done,
  output logic [3:0]  sign,
  output logic [3:0]  digit4,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0
);

  localparam logic [3:0] CODE_DASH  = 4'hB;
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] LAST_ITER  = 4'd15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    BLANK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] value_q;
  logic        neg_q;
  logic [16:0] mag_q;
  logic [19:0] bcd_q;
  logic [3:0]  iter_q;

  logic        accept_num;
  logic        accept_err;
  logic [16:0] magnitude;
  logic [19:0] bcd_adj;
  logic [3:0]  bcd_d4;
  logic [3:0]  bcd_d3;
  logic [3:0]  bcd_d2;
  logic [3:0]  bcd_d1;
  logic [3:0]  bcd_d0;
  logic        blank4;
  logic        blank3;
  logic        blank2;
  logic        blank1;

  // The largest magnitude is 32768, so bit 16 of the magnitude and the top
  // bit of the adjusted BCD are always zero and never need to be consumed.
  logic        unused_bits;
  assign unused_bits = ^{mag_q[16], bcd_adj[19]};

  assign accept_num = (state == IDLE) && start && !error;
  assign accept_err = (state == IDLE) && start && error;

  // Sign-extend to 17 bits before negating so that -32768 maps to +32768.
  assign magnitude = value_q[15] ? (17'd0 - {1'b1, value_q}) : {1'b0, value_q};

  assign busy = (state == LOAD) || (state == SHIFT) || (state == BLANK);

  // Add-3 correction for every BCD nibble that would overflow when doubled
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero detection on the finished BCD result; digit0 always shows
  always_comb begin
    bcd_d4 = bcd_q[19:16];
    bcd_d3 = bcd_q[15:12];
    bcd_d2 = bcd_q[11:8];
    bcd_d1 = bcd_q[7:4];
    bcd_d0 = bcd_q[3:0];
    blank4 = (bcd_d4 == 4'd0);
    blank3 = blank4 && (bcd_d3 == 4'd0);
    blank2 = blank3 && (bcd_d2 == 4'd0);
    blank1 = blank2 && (bcd_d1 == 4'd0);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_num) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (iter_q == LAST_ITER) state_nxt = BLANK;
      BLANK:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, magnitude load and double-dabble shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_num) value_q <= value;
        end
        LOAD: begin
          neg_q  <= value_q[15];
          mag_q  <= magnitude;
          bcd_q  <= '0;
          iter_q <= '0;
        end
        SHIFT: begin
          // Bit 15 is the highest bit that can be set in the magnitude.
          bcd_q  <= {bcd_adj[18:0], mag_q[15]};
          mag_q  <= {mag_q[15:0], 1'b0};
          iter_q <= iter_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Display registers and done pulse; they change only on a result edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done   <= 1'b0;
      sign   <= CODE_BLANK;
      digit4 <= CODE_BLANK;
      digit3 <= CODE_BLANK;
      digit2 <= CODE_BLANK;
      digit1 <= CODE_BLANK;
      digit0 <= 4'h0;
    end else begin
      done <= 1'b0;
      if (accept_err) begin
        done   <= 1'b1;
        sign   <= CODE_DASH;
        digit4 <= CODE_DASH;
        digit3 <= CODE_DASH;
        digit2 <= CODE_DASH;
        digit1 <= CODE_DASH;
        digit0 <= CODE_DASH;
      end else if (state == BLANK) begin
        done   <= 1'b1;
        sign   <= neg_q ? CODE_DASH : CODE_BLANK;
        digit4 <= blank4 ? CODE_BLANK : bcd_d4;
        digit3 <= blank3 ? CODE_BLANK : bcd_d3;
        digit2 <= blank2 ? CODE_BLANK : bcd_d2;
        digit1 <= blank1 ? CODE_BLANK : bcd_d1;
        digit0 <= bcd_d0;
      end
    end
  end

endmodule

// File: tb/tb_value_to_digits.sv
// Testbench for value_to_digits: vector table plus random operands through a
// scoreboard queue, then hand-written sequences for the multi-cycle cases.
`timescale 1ns/1ps
module tb_value_to_digits;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] value;
  logic        error;
  logic        busy;
  logic        done;
  logic [3:0]  sign;
  logic [3:0]  digit4;
  logic [3:0]  digit3;
  logic [3:0]  digit2;
  logic [3:0]  digit1;
  logic [3:0]  digit0;

  always #5 clk = ~clk;

  value_to_digits dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .value   (value),
    .error   (error),
    .busy    (busy),
    .done    (done),
    .sign    (sign),
    .digit4  (digit4),
    .digit3  (digit3),
    .digit2  (digit2),
    .digit1  (digit1),
    .digit0  (digit0)
  );

  typedef struct {
    logic [15:0] v;
    logic        e;
    logic [23:0] x;
  } vec_t;

  vec_t        vecs [14];
  logic [23:0] exp_q [$];
  logic [23:0] last_exp;
  logic [23:0] mon_exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] outs();
    return {sign, digit4, digit3, digit2, digit1, digit0};
  endfunction

  // Reference model: decimal digits by division, blank above the leading digit.
  function automatic logic [23:0] model(input logic [15:0] v);
    int          m;
    int          p;
    logic [23:0] r;
    m = int'($signed(v));
    r[23:20] = (m < 0) ? 4'hB : 4'hF;
    if (m < 0) m = -m;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0 && m < p) r[i*4 +: 4] = 4'hF;
      else                r[i*4 +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {8'h0, outs()}, {8'h0, mon_exp});
      end
    end
  end

  // One conversion: request, then check latency, busy window and pulse width.
  task automatic do_conv(input logic [15:0] v, input logic e, input logic [23:0] x);
    int cyc;
    int bcnt;
    @(negedge clk);
    start = 1'b1;
    value = v;
    error = e;
    exp_q.push_back(x);
    @(posedge clk); #1;
    start    = 1'b0;
    value    = ~v;
    error    = 1'b1;
    last_exp = x;
    if (e) begin
      check("err_done", {31'b0, done}, 32'd1);
      check("err_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      check("err_done_width", {31'b0, done}, 32'd0);
      check("err_busy_after", {31'b0, busy}, 32'd0);
    end else begin
      cyc  = 0;
      bcnt = 0;
      while (done !== 1'b1 && cyc < 40) begin
        if (busy === 1'b1) bcnt++;
        @(posedge clk); #1;
        cyc++;
      end
      check("latency", cyc, 32'd18);
      check("busy_cycles", bcnt, 32'd18);
      check("busy_at_done", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      check("done_width", {31'b0, done}, 32'd0);
    end
    error = 1'b0;
  endtask

  // Outputs must hold while inputs wander with start low.
  task automatic check_hold();
    repeat (4) begin
      @(negedge clk);
      value = 16'($urandom);
      error = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    check("hold", {8'h0, outs()}, {8'h0, last_exp});
    error = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int c1;
    int c2;
    logic [15:0] rv;

    vecs[0]  = '{16'd0,     1'b0, 24'hFFFFF0};
    vecs[1]  = '{16'd12345, 1'b0, 24'hF12345};
    vecs[2]  = '{16'h8000,  1'b0, 24'hB32768};
    vecs[3]  = '{16'hFFF9,  1'b0, 24'hBFFFF7};
    vecs[4]  = '{16'd1234,  1'b1, 24'hBBBBBB};
    vecs[5]  = '{16'd32767, 1'b0, 24'hF32767};
    vecs[6]  = '{16'hFFFF,  1'b0, 24'hBFFFF1};
    vecs[7]  = '{16'd10,    1'b0, 24'hFFFF10};
    vecs[8]  = '{16'd100,   1'b0, 24'hFFF100};
    vecs[9]  = '{16'hFC18,  1'b0, 24'hBF1000};
    vecs[10] = '{16'hFFFB,  1'b1, 24'hBBBBBB};
    vecs[11] = '{16'd9999,  1'b0, 24'hFF9999};
    vecs[12] = '{16'd10000, 1'b0, 24'hF10000};
    vecs[13] = '{16'd5,     1'b0, 24'hFFFFF5};

    reset_n = 1'b0;
    start   = 1'b0;
    value   = 16'd0;
    error   = 1'b0;
    last_exp = 24'hFFFFF0;

    @(posedge clk); #1;
    check("reset_outs", {8'h0, outs()}, 32'h00FFFFF0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_conv(vecs[i].v, vecs[i].e, vecs[i].x);
      if (i == 1 || i == 4) check_hold();
    end

    for (int i = 0; i < 8; i++) begin
      rv = 16'($urandom);
      do_conv(rv, 1'b0, model(rv));
    end

    // Extra start requests while busy must be ignored.
    @(negedge clk);
    start = 1'b1; value = 16'd999; error = 1'b0;
    exp_q.push_back(24'hFFF999);
    @(posedge clk); #1;
    start = 1'b0; value = 16'd0;
    cyc = 0;
    repeat (4) begin @(posedge clk); cyc++; end
    @(negedge clk);
    start = 1'b1; value = 16'd1;
    @(posedge clk); #1; cyc++;
    start = 1'b0;
    repeat (2) begin @(posedge clk); cyc++; end
    @(negedge clk);
    start = 1'b1; value = 16'd7; error = 1'b1;
    @(posedge clk); #1; cyc++;
    start = 1'b0; error = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_ignore_latency", cyc, 32'd18);
    repeat (25) @(posedge clk);
    #1;
    check("busy_ignore_queue", exp_q.size(), 32'd0);
    last_exp = 24'hFFF999;
    check_hold();

    // start held high: second conversion begins after DONE returns to IDLE.
    exp_q.push_back(24'hFFFF42);
    exp_q.push_back(24'hFFFF42);
    @(negedge clk);
    start = 1'b1; value = 16'd42; error = 1'b0;
    cyc = 0; c1 = -1; c2 = -1;
    while (c2 < 0 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) begin
        if (c1 < 0) c1 = cyc;
        else        c2 = cyc;
      end
    end
    start = 1'b0;
    check("held_first_done", c1, 32'd19);
    check("held_second_done", c2, 32'd39);
    repeat (25) @(posedge clk);
    #1;
    check("held_queue", exp_q.size(), 32'd0);

    // Reset in the middle of a conversion aborts it with no done pulse.
    @(negedge clk);
    start = 1'b1; value = 16'd12345; error = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_outs", {8'h0, outs()}, 32'h00FFFFF0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_done_held", {31'b0, done}, 32'd0);
    reset_n = 1'b1;
    do_conv(16'd12345, 1'b0, 24'hF12345);
    do_conv(16'hFF9C, 1'b0, 24'hBFF100);
    repeat (25) @(posedge clk);
    #1;
    check("final_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
